morra_match_driver: RTL and testbench
=====================================

# morra_match_driver

Match sequencer that drives the opposite side of the Morracinese game interface. It configures a match by pulsing the game's reset with a length code on the move buses, then plays two pseudo-random players one move per cycle, collects the per-manche and match results, and reports the winner and statistics. It sits alongside Morracinese in self-checking and demo top levels, with its outputs wired directly to the game's `g1`/`g2`/`reset` inputs.

## Interface
- `SEED1`, 8'hA5: player 1 LFSR seed. A value of 0 is replaced by 8'h01.
- `SEED2`, 8'h3C: player 2 LFSR seed. A value of 0 is replaced by 8'h01.
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  begin a match; sampled in IDLE or DONE
- `cfg`  in  4  match length code; the game's manche maximum is cfg+4
- `g1`  out  2  player 1 move to the game
- `g2`  out  2  player 2 move to the game
- `game_reset`  out  1  reset/config strobe to the game
- `manche`  in  2  per-round result from the game
- `partita`  in  2  match result from the game
- `busy`  out  1  high in CONFIG and PLAY
- `done`  out  1  one-cycle pulse on entering DONE
- `winner`  out  2  latched partita value; 00 on timeout
- `rounds`  out  5  results sampled, saturating at 31
- `invalid_cnt`  out  5  results with manche=00, saturating
- `timeout`  out  1  match ended without a partita result

## Operation
- Encodings:
  - Moves: 00 none, 01 sasso, 10 carta, 11 forbice.
  - `manche`: 00 invalid, 01 g1 wins, 10 g2 wins, 11 draw.
  - `partita`: 00 in progress, 01 g1, 10 g2, 11 draw.
- Reset values: state IDLE, `game_reset`=1, `g1`=`g2`=00, `busy`=`done`=`timeout`=0, `winner`=00, `rounds`=`invalid_cnt`=0, LFSRs loaded with their seeds.
- IDLE:
  - `game_reset`=1, moves 00.
  - On `start`: go to CONFIG, reload LFSRs from seeds, clear the counters, `timeout`, and `winner`.
- CONFIG (1 cycle):
  - `game_reset`=1, `g1`=`cfg[3:2]`, `g2`=`cfg[1:0]`.
  - Go to PLAY and clear the `pending` flag.
- PLAY (every cycle):
  - `game_reset`=0.
  - `gN` = current LFSR[1:0]; a value of 00 is mapped to 01.
  - Both LFSRs advance.
  - Set `pending`=1.
- LFSR: 8-bit Galois, right shift; if lsb=1, `next = (s>>1) ^ 8'hB8`, otherwise `s>>1`.
- Result sampling in PLAY, only when `pending`=1:
  - `rounds`++.
  - `invalid_cnt`++ if `manche`==00.
  - If `partita`≠00: latch `winner`=`partita`, go to DONE.
  - Otherwise, if `rounds` reaches 31: `timeout`=1, `winner`=00, go to DONE.
- No-repeat rule: the driver does not enforce the game's rule against repeating a winning move. Moves that break the rule are legal stimulus and show up in `invalid_cnt`.
- DONE:
  - Moves 00, `game_reset`=0.
  - `winner`, `rounds`, `invalid_cnt`, and `timeout` are held.
  - `start` goes to CONFIG, performing the same clears as IDLE→CONFIG.
- `start` in CONFIG or PLAY is ignored.
- Assertion of `reset` at any time returns the block to the reset values immediately, without waiting for a clock edge.

## Timing
- The game registers moves, so the result of the move presented in cycle k is sampled at the end of cycle k+1.
  - The move presented in the cycle that observes `partita`≠00 is discarded.
- `start` sampled at edge E0:
  - CONFIG occupies cycle E0..E1.
  - The first move is presented in E1..E2.
  - The first result is sampled at E3.
- `done` is high for exactly the first DONE cycle.
- `winner` is valid from that cycle until the next `start` or `reset`.
- Simultaneous `partita`≠00 and `rounds` reaching 31: the partita result takes priority and `timeout` stays 0.

## Structure
- `morra_pkg` holds:
  - Move, manche, and partita enums.
  - `LFSR_POLY` = 8'hB8.
  - `MANCHE_OFFSET` = 4.
  - `RESULT_CNT_MAX` = 31.
  - The state enum `{IDLE, CONFIG, PLAY, DONE}`.
- Sub-module `morra_lfsr_player`:
  - Inputs: seed, load, advance.
  - Output: move, with 00→01 mapping.
  - Instantiated twice.

## Test plan
- Reset, then `start` with `cfg`=0000: one CONFIG cycle with `game_reset`=1 and `g1`=`g2`=00, then `game_reset` falls. With `SEED1`=8'h01, `g1` sequence is 01,01,01,10,11.
- Behavioral game model ends the match with `partita`=11 after 4 results: `done` pulses once, `winner`=11, `rounds`=4, `timeout`=0, and moves return to 00.
- Model returns `manche`=00 three times, then `partita`=10 on the 6th result: `invalid_cnt`=3, `rounds`=6, `winner`=10.
- Model never ends: after 31 results, `timeout`=1, `winner`=00, `done` pulses, and `rounds` holds at 31.
- `reset` asserted mid-PLAY: all outputs take reset values without waiting for a clock edge. Then `start` with `cfg`=1111: CONFIG drives `g1`=11, `g2`=11.
- `start` pulsed during PLAY: ignored, with no LFSR reload. `start` in DONE restarts the match with the counters cleared.

Source files
------------

// File: rtl/morra_pkg.sv
// Shared types and constants for the Morracinese match driver.
// Move/result encodings follow the game interface bit-for-bit.
package morra_pkg;

    typedef enum logic [1:0] {
        MOVE_NONE    = 2'b00,
        MOVE_SASSO   = 2'b01,
        MOVE_CARTA   = 2'b10,
        MOVE_FORBICE = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        MANCHE_INVALID = 2'b00,
        MANCHE_G1      = 2'b01,
        MANCHE_G2      = 2'b10,
        MANCHE_DRAW    = 2'b11
    } manche_t;

    typedef enum logic [1:0] {
        PARTITA_NONE = 2'b00,
        PARTITA_G1   = 2'b01,
        PARTITA_G2   = 2'b10,
        PARTITA_DRAW = 2'b11
    } partita_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CONFIG = 2'b01,
        PLAY   = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam logic [7:0] LFSR_POLY      = 8'hB8;
    localparam int         MANCHE_OFFSET  = 4;
    localparam logic [4:0] RESULT_CNT_MAX = 5'd31;

    // Galois right-shift step; the poly is folded in when a one drops out.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // An all-zero LFSR would lock up, so zero seeds are forced to one.
    function automatic logic [7:0] seed_fix(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    // The game treats 00 as "no move", so a player never emits it.
    function automatic logic [1:0] move_map(input logic [1:0] m);
        return (m == 2'b00) ? 2'b01 : m;
    endfunction

endpackage

// File: rtl/morra_lfsr_player.sv
// Pseudo-random player: an 8-bit Galois LFSR whose low bits become a move.
module morra_lfsr_player
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    input  logic       load,
    input  logic       advance,
    output logic [1:0] move
);

    logic [7:0] lfsr_r;

    // LFSR state: seed on reset or load, one step per advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= seed_fix(seed);
        end else if (load) begin
            lfsr_r <= seed_fix(seed);
        end else if (advance) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign move = move_map(lfsr_r[1:0]);

endmodule

// File: rtl/morra_match_driver.sv
// Match sequencer for the Morracinese game: configures a match, plays two
// LFSR players one move per cycle and collects winner and statistics.
module morra_match_driver
    import morra_pkg::*;
#(
    parameter logic [7:0] SEED1 = 8'hA5,
    parameter logic [7:0] SEED2 = 8'h3C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] cfg,
    output logic [1:0] g1,
    output logic [1:0] g2,
    output logic       game_reset,
    input  logic [1:0] manche,
    input  logic [1:0] partita,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner,
    output logic [4:0] rounds,
    output logic [4:0] invalid_cnt,
    output logic       timeout
);

    state_t     state_r;
    state_t     state_s;
    logic       pending_r;
    logic       done_r;
    logic       timeout_r;
    logic [1:0] winner_r;
    logic [4:0] rounds_r;
    logic [4:0] invalid_r;
    logic [1:0] p1_move_s;
    logic [1:0] p2_move_s;
    logic       match_start_s;
    logic       sample_s;
    logic       last_round_s;
    logic       play_s;
    logic [1:0] g1_s;
    logic [1:0] g2_s;
    logic       game_reset_s;
    logic       busy_s;

    assign play_s        = (state_r == PLAY);
    assign match_start_s = start && ((state_r == IDLE) || (state_r == DONE));
    // The game registers moves, so results are only meaningful one cycle into PLAY.
    assign sample_s      = play_s && pending_r;
    assign last_round_s  = (rounds_r == (RESULT_CNT_MAX - 5'd1));

    morra_lfsr_player u_player1 (
        .clk     (clk),
        .rst     (reset),
        .seed    (SEED1),
        .load    (match_start_s),
        .advance (play_s),
        .move    (p1_move_s)
    );

    morra_lfsr_player u_player2 (
        .clk     (clk),
        .rst     (reset),
        .seed    (SEED2),
        .load    (match_start_s),
        .advance (play_s),
        .move    (p2_move_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a partita result outranks the round-limit timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = CONFIG;
                else       state_s = IDLE;
            end
            CONFIG: begin
                state_s = PLAY;
            end
            PLAY: begin
                if (sample_s && (partita != PARTITA_NONE)) state_s = DONE;
                else if (sample_s && last_round_s)         state_s = DONE;
                else                                       state_s = PLAY;
            end
            DONE: begin
                if (start) state_s = CONFIG;
                else       state_s = DONE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode for the game-facing signals.
    always_comb begin
        game_reset_s = 1'b1;
        g1_s         = MOVE_NONE;
        g2_s         = MOVE_NONE;
        busy_s       = 1'b0;
        case (state_r)
            IDLE: begin
                game_reset_s = 1'b1;
            end
            CONFIG: begin
                g1_s   = cfg[3:2];
                g2_s   = cfg[1:0];
                busy_s = 1'b1;
            end
            PLAY: begin
                game_reset_s = 1'b0;
                g1_s         = p1_move_s;
                g2_s         = p2_move_s;
                busy_s       = 1'b1;
            end
            DONE: begin
                game_reset_s = 1'b0;
            end
            default: begin
                game_reset_s = 1'b1;
            end
        endcase
    end

    // Pending flag, result counters and the latched outcome.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            winner_r  <= 2'b00;
            rounds_r  <= 5'd0;
            invalid_r <= 5'd0;
        end else begin
            done_r <= (state_r != DONE) && (state_s == DONE);
            if (state_r == CONFIG) begin
                pending_r <= 1'b0;
            end else if (play_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
            if (match_start_s) begin
                timeout_r <= 1'b0;
                winner_r  <= 2'b00;
                rounds_r  <= 5'd0;
                invalid_r <= 5'd0;
            end else if (sample_s) begin
                rounds_r <= (rounds_r == RESULT_CNT_MAX) ? rounds_r : rounds_r + 5'd1;
                if ((manche == MANCHE_INVALID) && (invalid_r != RESULT_CNT_MAX)) begin
                    invalid_r <= invalid_r + 5'd1;
                end else begin
                    invalid_r <= invalid_r;
                end
                if (partita != PARTITA_NONE) begin
                    winner_r  <= partita;
                    timeout_r <= timeout_r;
                end else if (last_round_s) begin
                    winner_r  <= 2'b00;
                    timeout_r <= 1'b1;
                end else begin
                    winner_r  <= winner_r;
                    timeout_r <= timeout_r;
                end
            end else begin
                timeout_r <= timeout_r;
                winner_r  <= winner_r;
                rounds_r  <= rounds_r;
                invalid_r <= invalid_r;
            end
        end
    end

    assign g1          = g1_s;
    assign g2          = g2_s;
    assign game_reset  = game_reset_s;
    assign busy        = busy_s;
    assign done        = done_r;
    assign winner      = winner_r;
    assign rounds      = rounds_r;
    assign invalid_cnt = invalid_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_morra_match_driver.sv
// Scoreboard bench: a scripted game model answers each move; expected moves
// and match results are queued up front and checked by a negedge monitor.
module tb_morra_match_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] cfg;
    logic [1:0] manche;
    logic [1:0] partita;
    logic [1:0] g1, g2, winner;
    logic       game_reset, busy, done, timeout;
    logic [4:0] rounds, invalid_cnt;

    int checks = 0;
    int failures = 0;
    int idx = 0;
    int n;

    logic [1:0]  scr_manche  [0:39];
    logic [1:0]  scr_partita [0:39];
    logic [3:0]  move_q [$];
    logic [12:0] res_q  [$];

    // Hand-computed LFSR moves from SEED1=01 and SEED2=3C, as {g1,g2}.
    logic [3:0] exp_moves [0:6] = '{4'b0101, 4'b0110, 4'b0111, 4'b1011,
                                    4'b1111, 4'b1111, 4'b0101};

    morra_match_driver #(.SEED1(8'h01), .SEED2(8'h3C)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg(cfg),
        .g1(g1), .g2(g2), .game_reset(game_reset),
        .manche(manche), .partita(partita),
        .busy(busy), .done(done), .winner(winner), .rounds(rounds),
        .invalid_cnt(invalid_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Game model: result of move k is presented during move k+1's cycle.
    always @(negedge clk) begin
        if (busy && !game_reset) begin
            idx = idx + 1;
            if (idx >= 2 && idx <= 41) begin
                manche  = scr_manche[idx-2];
                partita = scr_partita[idx-2];
            end else begin
                manche  = 2'b00;
                partita = 2'b00;
            end
        end else begin
            manche  = 2'b00;
            partita = 2'b00;
        end
    end

    // Monitor: pops expected moves and match results as the DUT presents them.
    always @(negedge clk) begin
        if (busy && !game_reset && move_q.size() > 0)
            check("move", {g1, g2}, move_q.pop_front());
        if (done) begin
            if (res_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                check("result", {winner, rounds, invalid_cnt, timeout}, res_q.pop_front());
            end
        end
    end

    task automatic set_script(input logic [1:0] m);
        for (int i = 0; i < 40; i++) begin
            scr_manche[i]  = m;
            scr_partita[i] = 2'b00;
        end
    endtask

    task automatic do_start(input logic [3:0] c);
        @(negedge clk);
        cfg = c;
        start = 1'b1;
        idx = 0;
        @(negedge clk);
        start = 1'b0;
        check("config_game_reset", game_reset, 1'b1);
        check("config_g1", g1, c[3:2]);
        check("config_g2", g2, c[1:0]);
        check("config_busy", busy, 1'b1);
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        while (cyc < maxc && !done) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic after_done();
        @(negedge clk);
        check("done_pulse_len", done, 1'b0);
        check("done_moves", {g1, g2}, 4'b0000);
        check("done_game_reset", game_reset, 1'b0);
        check("done_busy", busy, 1'b0);
        check("move_q_empty", move_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_game_reset"}, game_reset, 1'b1);
        check({tag, "_moves"}, {g1, g2}, 4'b0000);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_stats"}, {winner, rounds, invalid_cnt, timeout}, 13'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cfg = 4'h0;
        manche = 2'b00; partita = 2'b00;
        set_script(2'b01);
        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b0;

        // Match ends on a draw after 4 results.
        set_script(2'b01);
        scr_manche[1] = 2'b10; scr_manche[2] = 2'b11; scr_partita[3] = 2'b11;
        for (int i = 0; i < 5; i++) move_q.push_back(exp_moves[i]);
        res_q.push_back({2'b11, 5'd4, 5'd0, 1'b0});
        do_start(4'h0);
        wait_done(20, n);
        check("s1_latency", n, 6);
        after_done();

        // Three invalid rounds, then player 2 wins on result 6 (restart from DONE).
        set_script(2'b01);
        scr_manche[0] = 2'b00; scr_manche[1] = 2'b00; scr_manche[2] = 2'b00;
        scr_manche[5] = 2'b10; scr_partita[5] = 2'b10;
        for (int i = 0; i < 7; i++) move_q.push_back(exp_moves[i]);
        res_q.push_back({2'b10, 5'd6, 5'd3, 1'b0});
        do_start(4'h0);
        wait_done(20, n);
        check("s2_latency", n, 8);
        after_done();

        // start during PLAY is ignored: the move sequence must not restart.
        set_script(2'b01);
        scr_partita[3] = 2'b01;
        for (int i = 0; i < 5; i++) move_q.push_back(exp_moves[i]);
        res_q.push_back({2'b01, 5'd4, 5'd0, 1'b0});
        do_start(4'h5);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20, n);
        after_done();

        // Endless match times out after 31 results.
        set_script(2'b01);
        res_q.push_back({2'b00, 5'd31, 5'd0, 1'b1});
        do_start(4'h0);
        wait_done(60, n);
        check("s3_latency", n, 33);
        after_done();
        repeat (3) @(negedge clk);
        check("timeout_hold", {winner, rounds, timeout}, {2'b00, 5'd31, 1'b1});

        // Partita on result 31 beats the timeout.
        set_script(2'b01);
        scr_partita[30] = 2'b10;
        res_q.push_back({2'b10, 5'd31, 5'd0, 1'b0});
        do_start(4'h0);
        wait_done(60, n);
        after_done();

        // Asynchronous reset in the middle of PLAY, then a cfg=1111 start.
        set_script(2'b01);
        do_start(4'h0);
        repeat (4) @(negedge clk);
        check("pre_reset_rounds_nonzero", rounds != 5'd0, 1'b1);
        #1 reset = 1'b1;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        reset = 1'b0;
        do_start(4'hF);
        repeat (3) @(negedge clk);
        check("res_q_empty", res_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
